// File: rtl/id_stage.sv
// Instruction-decode stage: GPR address split, op decode, load-use hazard detect, ID/EX register.
// Optional EX-result bypass into the operand capture is enabled by defining ID_FWD_EN.
module id_stage #(
  parameter int WORD       = 32,
  parameter int GPR_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [WORD-1:0]       if_pc,
  input  logic [WORD-1:0]       if_insn,
  input  logic                  stall,
  input  logic                  flush,
  output logic [GPR_ADDR_W-1:0] gpr_rd_addr_0,
  output logic [GPR_ADDR_W-1:0] gpr_rd_addr_1,
  input  logic [WORD-1:0]       gpr_rd_data_0,
  input  logic [WORD-1:0]       gpr_rd_data_1,
  input  logic                  ex_fwd_we,
  input  logic [GPR_ADDR_W-1:0] ex_fwd_addr,
  input  logic [WORD-1:0]       ex_fwd_data,
  output logic                  stall_req,
  output logic                  id_valid,
  output logic [WORD-1:0]       id_pc,
  output logic [5:0]            id_op,
  output logic [GPR_ADDR_W-1:0] id_dst,
  output logic                  id_gpr_we,
  output logic                  id_is_load,
  output logic                  id_is_store,
  output logic                  id_is_branch,
  output logic                  id_illegal,
  output logic [WORD-1:0]       id_ra_data,
  output logic [WORD-1:0]       id_rb_data,
  output logic [WORD-1:0]       id_imm
);

  logic [5:0]            op;
  logic [GPR_ADDR_W-1:0] ra, rb, rd;
  logic [WORD-1:0]       imm_ext;

  assign op      = if_insn[31:26];
  assign ra      = if_insn[25:21];
  assign rb      = if_insn[20:16];
  assign rd      = if_insn[15:11];
  assign imm_ext = {{(WORD-16){if_insn[15]}}, if_insn[15:0]};

  assign gpr_rd_addr_0 = ra;
  assign gpr_rd_addr_1 = rb;

  logic [GPR_ADDR_W-1:0] dec_dst;
  logic dec_we, dec_uses_rb, dec_load, dec_store, dec_branch, dec_illegal;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a signal unassigned (no latch).
    dec_dst     = rb;
    dec_we      = 1'b0;
    dec_uses_rb = 1'b0;
    dec_load    = 1'b0;
    dec_store   = 1'b0;
    dec_branch  = 1'b0;
    dec_illegal = 1'b0;
    case (op) inside
      6'h00:          begin dec_dst = rd; dec_we = 1'b1; dec_uses_rb = 1'b1; end
      [6'h01:6'h0F]:  dec_we = 1'b1;
      6'h10:          begin dec_we = 1'b1; dec_load = 1'b1; end
      6'h11:          begin dec_store = 1'b1; dec_uses_rb = 1'b1; end
      [6'h12:6'h13]:  begin dec_branch = 1'b1; dec_uses_rb = 1'b1; end
      default:        dec_illegal = 1'b1;
    endcase
  end

  logic [WORD-1:0] ra_sel, rb_sel;

`ifdef ID_FWD_EN
  assign ra_sel = (ex_fwd_we && ex_fwd_addr == ra) ? ex_fwd_data : gpr_rd_data_0;
  assign rb_sel = (ex_fwd_we && ex_fwd_addr == rb) ? ex_fwd_data : gpr_rd_data_1;
`else
  // Bypass ports stay on the boundary but are ignored in this build.
  logic unused_fwd;
  assign unused_fwd = ^{ex_fwd_we, ex_fwd_addr, ex_fwd_data};
  assign ra_sel = gpr_rd_data_0;
  assign rb_sel = gpr_rd_data_1;
`endif

  logic                  valid_q, we_q, load_q, store_q, branch_q, illegal_q;
  logic [WORD-1:0]       pc_q, ra_q, rb_q, imm_q;
  logic [5:0]            op_q;
  logic [GPR_ADDR_W-1:0] dst_q;

  // Register 0 is deliberately not exempt from the hazard compare.
  assign stall_req = if_valid & id_valid & id_is_load &
                     ((id_dst == ra) | (dec_uses_rb & (id_dst == rb)));

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: datapath fields are reset too, since every registered output must read 0 in reset.
    if (!rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      op_q      <= '0;
      dst_q     <= '0;
      we_q      <= 1'b0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
      ra_q      <= '0;
      rb_q      <= '0;
      imm_q     <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (stall) begin
      // hold everything, including a pending load-use bubble
    end else if (stall_req) begin
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all fields sample the same pre-edge values.
      valid_q   <= if_valid;
      pc_q      <= if_pc;
      op_q      <= op;
      dst_q     <= dec_dst;
      we_q      <= dec_we;
      load_q    <= dec_load;
      store_q   <= dec_store;
      branch_q  <= dec_branch;
      illegal_q <= dec_illegal;
      ra_q      <= ra_sel;
      rb_q      <= rb_sel;
      imm_q     <= imm_ext;
    end
  end

  // Control flags are qualified by valid so a bubble or flushed slot never acts.
  assign id_valid     = valid_q;
  assign id_pc        = pc_q;
  assign id_op        = op_q;
  assign id_dst       = dst_q;
  assign id_gpr_we    = valid_q & we_q;
  assign id_is_load   = valid_q & load_q;
  assign id_is_store  = valid_q & store_q;
  assign id_is_branch = valid_q & branch_q;
  assign id_illegal   = valid_q & illegal_q;
  assign id_ra_data   = ra_q;
  assign id_rb_data   = rb_q;
  assign id_imm       = imm_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed instruction vectors push expected ID results,
// a monitor pops and compares whenever id_valid is presented.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_insn = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1;
  logic [31:0] gpr_rd_data_0, gpr_rd_data_1;
  logic        ex_fwd_we = 1'b0;
  logic [4:0]  ex_fwd_addr = '0;
  logic [31:0] ex_fwd_data = '0;
  logic        stall_req, id_valid, id_gpr_we, id_is_load, id_is_store, id_is_branch, id_illegal;
  logic [31:0] id_pc, id_ra_data, id_rb_data, id_imm;
  logic [5:0]  id_op;
  logic [4:0]  id_dst;

  logic [31:0] gpr [32];
  assign gpr_rd_data_0 = gpr[gpr_rd_addr_0];
  assign gpr_rd_data_1 = gpr[gpr_rd_addr_1];

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_insn(if_insn),
    .stall(stall), .flush(flush),
    .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1),
    .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
    .ex_fwd_we(ex_fwd_we), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
    .stall_req(stall_req), .id_valid(id_valid), .id_pc(id_pc), .id_op(id_op),
    .id_dst(id_dst), .id_gpr_we(id_gpr_we), .id_is_load(id_is_load),
    .id_is_store(id_is_store), .id_is_branch(id_is_branch), .id_illegal(id_illegal),
    .id_ra_data(id_ra_data), .id_rb_data(id_rb_data), .id_imm(id_imm)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  dst;
    logic        we, ld, st, br, ill;
    logic [31:0] ra, rb, imm;
  } exp_t;

`ifdef ID_FWD_EN
  localparam logic [31:0] FWD_EXP = 32'hDEADBEEF;
`else
  localparam logic [31:0] FWD_EXP = 32'h0;
`endif

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(input logic [31:0] pc, input logic [5:0] op, input logic [4:0] dst,
                              input logic we, ld, st, br, ill,
                              input logic [31:0] ra, rb, imm);
    exp_t e;
    e = '{pc: pc, op: op, dst: dst, we: we, ld: ld, st: st, br: br, ill: ill,
          ra: ra, rb: rb, imm: imm};
    return e;
  endfunction

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a valid result it must match the next expectation.
  always @(posedge clk) begin
    #1;
    if (id_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got pc %h expected no valid output", id_pc);
      end else begin
        check("id_result",
              mk(id_pc, id_op, id_dst, id_gpr_we, id_is_load, id_is_store, id_is_branch,
                 id_illegal, id_ra_data, id_rb_data, id_imm),
              sb.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                       input logic s, input logic f);
    @(negedge clk);
    if_valid = v;
    if_pc    = pc;
    if_insn  = insn;
    stall    = s;
    flush    = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e7;
    for (int i = 0; i < 32; i++) gpr[i] = '0;
    gpr[1] = 32'h55; gpr[2] = 32'h33; gpr[3] = 32'h66; gpr[4] = 32'hAB;
    gpr[5] = 32'h11; gpr[6] = 32'h22; gpr[7] = 32'h44; gpr[9] = 32'h99;

    #2 rst = 1'b0;
    #1;
    check("reset_valid", id_valid, 0);
    check("reset_stall_req", stall_req, 0);
    check("reset_pc", id_pc, 0);

    // R-type r4 = r5 op r6
    drive(1, 32'h100, 32'h00A62000, 0, 0);
    rst = 1'b1;
    check("rd_addr_0", gpr_rd_addr_0, 5);
    check("rd_addr_1", gpr_rd_addr_1, 6);
    check("no_hazard_first", stall_req, 0);
    sb.push_back(mk(32'h100, 6'h00, 5'd4, 1, 0, 0, 0, 0, 32'h11, 32'h22, 32'h2000));
    tick();

    // ALU-immediate with negative immediate, dst = rb
    drive(1, 32'h104, 32'h0447FFFE, 0, 0);
    sb.push_back(mk(32'h104, 6'h01, 5'd7, 1, 0, 0, 0, 0, 32'h33, 32'h44, 32'hFFFFFFFE));
    tick();

    // LOAD r3
    drive(1, 32'h108, 32'h40230004, 0, 0);
    sb.push_back(mk(32'h108, 6'h10, 5'd3, 1, 1, 0, 0, 0, 32'h55, 32'h66, 32'h4));
    tick();

    // ALU-imm whose rb field matches the load dst: rb unused, so no hazard
    drive(1, 32'h10C, 32'h0423000C, 0, 0);
    check("imm_rb_no_hazard", stall_req, 0);
    sb.push_back(mk(32'h10C, 6'h01, 5'd3, 1, 0, 0, 0, 0, 32'h55, 32'h66, 32'hC));
    tick();

    drive(1, 32'h110, 32'h40230004, 0, 0);
    check("no_hazard_after_alu", stall_req, 0);
    sb.push_back(mk(32'h110, 6'h10, 5'd3, 1, 1, 0, 0, 0, 32'h55, 32'h66, 32'h4));
    tick();

    // Load-use on ra: one bubble, then the R-type issues with the bypassed load result
    drive(1, 32'h114, 32'h00664000, 0, 0);
    check("load_use_ra", stall_req, 1);
    tick();
    check("bubble_valid", id_valid, 0);
    gpr[3] = 32'h77;
    drive(1, 32'h114, 32'h00664000, 0, 0);
    check("after_bubble", stall_req, 0);
    sb.push_back(mk(32'h114, 6'h00, 5'd8, 1, 0, 0, 0, 0, 32'h77, 32'h22, 32'h4000));
    tick();

    // LOAD r9, then dependent R-type arrives while downstream stalls
    drive(1, 32'h118, 32'h40090000, 0, 0);
    e7 = mk(32'h118, 6'h10, 5'd9, 1, 1, 0, 0, 0, 32'h0, 32'h99, 32'h0);
    sb.push_back(e7);
    tick();
    drive(1, 32'h11C, 32'h01200800, 1, 0);
    check("hazard_under_stall", stall_req, 1);
    sb.push_back(e7);
    tick();
    drive(1, 32'h11C, 32'h01200800, 0, 0);
    check("hazard_after_stall", stall_req, 1);
    tick();
    check("bubble_after_stall", id_valid, 0);
    drive(1, 32'h11C, 32'h01200800, 0, 0);
    check("issue_after_stall", stall_req, 0);
    sb.push_back(mk(32'h11C, 6'h00, 5'd1, 1, 0, 0, 0, 0, 32'h99, 32'h0, 32'h800));
    tick();

    // LOAD r3, then STORE using r3 as rb: hazard, but flush wins
    drive(1, 32'h120, 32'h40230004, 0, 0);
    sb.push_back(mk(32'h120, 6'h10, 5'd3, 1, 1, 0, 0, 0, 32'h55, 32'h77, 32'h4));
    tick();
    drive(1, 32'h124, 32'h44030010, 0, 1);
    check("store_rb_hazard", stall_req, 1);
    tick();
    check("flush_valid", id_valid, 0);

    // STORE, BRANCH, illegal op
    drive(1, 32'h128, 32'h44800010, 0, 0);
    check("no_hazard_when_invalid", stall_req, 0);
    sb.push_back(mk(32'h128, 6'h11, 5'd0, 0, 0, 1, 0, 0, 32'hAB, 32'h0, 32'h10));
    tick();
    drive(1, 32'h12C, 32'h488007F0, 0, 0);
    sb.push_back(mk(32'h12C, 6'h12, 5'd0, 0, 0, 0, 1, 0, 32'hAB, 32'h0, 32'h7F0));
    tick();
    drive(1, 32'h130, 32'hFC0007FF, 0, 0);
    sb.push_back(mk(32'h130, 6'h3F, 5'd0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h7FF));
    tick();

    // flush and stall together: flush wins, flags forced off
    drive(1, 32'h134, 32'h00A62000, 1, 1);
    tick();
    check("flush_stall_valid", id_valid, 0);
    check("illegal_forced_off", id_illegal, 0);

    // EX forwarding onto ra with GPR r5 = 0
    gpr[5] = 32'h0;
    ex_fwd_we = 1'b1; ex_fwd_addr = 5'd5; ex_fwd_data = 32'hDEADBEEF;
    drive(1, 32'h140, 32'h00A62000, 0, 0);
    sb.push_back(mk(32'h140, 6'h00, 5'd4, 1, 0, 0, 0, 0, FWD_EXP, 32'h22, 32'h2000));
    tick();
    ex_fwd_we = 1'b0;
    gpr[5] = 32'h11;

    // Asynchronous reset mid-cycle with id_valid = 1
    rst = 1'b0;
    #1;
    check("async_rst_valid", id_valid, 0);
    check("async_rst_pc", id_pc, 0);
    check("async_rst_ra", id_ra_data, 0);
    check("async_rst_dst", id_dst, 0);
    drive(1, 32'h144, 32'h00A62000, 0, 0);
    rst = 1'b1;
    sb.push_back(mk(32'h144, 6'h00, 5'd4, 1, 0, 0, 0, 0, 32'h11, 32'h22, 32'h2000));
    tick();

    drive(0, 32'h148, 32'h0, 0, 0);
    tick();
    check("idle_valid", id_valid, 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
